// File: rtl/data_memory_responder.sv
// Fixed-latency data memory: requests ride a LATENCY-deep shift pipeline and
// execute against a byte array when they leave the last stage, so responses stay in order.
module data_memory_responder #(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_store_value,
   input  logic        mem_BMS,
   input  logic        mem_LS,
   input  logic        mem_valid,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_load_value_out,
   output logic        mem_LS_out,
   output logic        mem_valid_out,
   output logic [3:0]  inflight_count
);

   localparam int AW = $clog2(DEPTH_BYTES);

   typedef struct packed {
      logic        vld;
      logic [31:0] addr;
      logic [31:0] data;
      logic        bms;
      logic        ls;
   } stage_t;

   stage_t           pipe [LATENCY];
   stage_t           fin;
   logic [7:0]       mem_array [DEPTH_BYTES];
   logic [AW-1:0]    idx;
   logic [AW-1:0]    base;
   logic [31:0]      load_word;

   assign fin  = pipe[LATENCY-1];
   assign idx  = fin.addr[AW-1:0];
   assign base = idx & ~AW'(3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= '{vld: mem_valid, addr: mem_address, data: mem_store_value,
                      bms: mem_BMS, ls: mem_LS};
         for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   // The array is deliberately outside the reset domain: contents survive reset.
   always_ff @(posedge clk) begin
      if (fin.vld && !fin.ls) begin
         if (fin.bms) begin
            mem_array[idx] <= fin.data[7:0];
         end else begin
            mem_array[base]          <= fin.data[7:0];
            mem_array[base + AW'(1)] <= fin.data[15:8];
            mem_array[base + AW'(2)] <= fin.data[23:16];
            mem_array[base + AW'(3)] <= fin.data[31:24];
         end
      end
   end

   always_comb begin
      load_word = '0;
      if (fin.bms) begin
         load_word = {{24{mem_array[idx][7]}}, mem_array[idx]};
      end else begin
         load_word = {mem_array[base + AW'(3)], mem_array[base + AW'(2)],
                      mem_array[base + AW'(1)], mem_array[base]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_valid_out      <= 1'b0;
         mem_addr_out       <= '0;
         mem_load_value_out <= '0;
         mem_LS_out         <= 1'b0;
      end else begin
         mem_valid_out <= fin.vld;
         if (fin.vld) begin
            mem_addr_out       <= fin.addr;
            mem_load_value_out <= fin.ls ? load_word : 32'h0;
            mem_LS_out         <= fin.ls;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_count <= '0;
      end else begin
         case ({mem_valid, fin.vld})
            2'b10:   inflight_count <= inflight_count + 4'd1;
            2'b01:   inflight_count <= inflight_count - 4'd1;
            default: inflight_count <= inflight_count;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized and directed bench for data_memory_responder against a byte-array
// reference model that resolves each request at acceptance time.
module tb_data_memory_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_address, mem_store_value;
   logic        mem_BMS, mem_LS, mem_valid;
   logic [31:0] mem_addr_out, mem_load_value_out;
   logic        mem_LS_out, mem_valid_out;
   logic [3:0]  inflight_count;

   data_memory_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .mem_address(mem_address), .mem_store_value(mem_store_value),
      .mem_BMS(mem_BMS), .mem_LS(mem_LS), .mem_valid(mem_valid),
      .mem_addr_out(mem_addr_out), .mem_load_value_out(mem_load_value_out),
      .mem_LS_out(mem_LS_out), .mem_valid_out(mem_valid_out),
      .inflight_count(inflight_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] val;
      logic        ls;
      int          cyc;
      logic        known;
      logic [31:0] kval;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  ref_mem [DEPTH];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          peak    = 0;
   logic        next_known;
   logic [31:0] next_kval;
   logic [31:0] last_addr, last_val;
   logic        last_ls;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model_exec(input logic [31:0] a, input logic [31:0] d,
                                              input logic bms, input logic ls);
      int unsigned i;
      logic [31:0] r;
      i = a % DEPTH;
      if (!bms) i = i - (i % 4);
      r = 0;
      if (!ls) begin
         if (bms) ref_mem[i] = d[7:0];
         else for (int b = 0; b < 4; b++) ref_mem[i+b] = d[8*b +: 8];
      end else if (bms) begin
         r = {{24{ref_mem[i][7]}}, ref_mem[i]};
      end else begin
         for (int b = 0; b < 4; b++) r[8*b +: 8] = ref_mem[i+b];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (!reset && mem_valid) begin
         e.addr  = mem_address;
         e.ls    = mem_LS;
         e.val   = model_exec(mem_address, mem_store_value, mem_BMS, mem_LS);
         e.cyc   = cyc + LAT;
         e.known = next_known;
         e.kval  = next_kval;
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (mem_valid_out) begin
         if (exp_q.size() == 0) begin
            check("spurious_resp", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("resp_addr", mem_addr_out, e.addr);
            check("resp_value", mem_load_value_out, e.val);
            check("resp_ls", {31'd0, mem_LS_out}, {31'd0, e.ls});
            check("resp_latency", cyc, e.cyc);
            if (e.known) check("directed_value", mem_load_value_out, e.kval);
         end
         last_addr = mem_addr_out;
         last_val  = mem_load_value_out;
         last_ls   = mem_LS_out;
      end else begin
         check("hold_addr", mem_addr_out, last_addr);
         check("hold_value", mem_load_value_out, last_val);
         check("hold_ls", {31'd0, mem_LS_out}, {31'd0, last_ls});
      end
      check("inflight", {28'd0, inflight_count}, exp_q.size());
      if (int'(inflight_count) > peak) peak = int'(inflight_count);
   end

   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic bms,
                      input logic ls, input logic known = 1'b0, input logic [31:0] kval = 0);
      mem_address = a; mem_store_value = d; mem_BMS = bms; mem_LS = ls;
      mem_valid = 1'b1; next_known = known; next_kval = kval;
      @(posedge clk); #1;
      mem_valid = 1'b0; next_known = 1'b0;
   endtask

   task automatic idle(input int n);
      mem_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      for (int k = 0; k < 4 * LAT + 4 && exp_q.size() != 0; k++) idle(1);
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      reset = 1'b1; mem_valid = 1'b0; mem_address = 0; mem_store_value = 0;
      mem_BMS = 0; mem_LS = 0; next_known = 0; next_kval = 0;
      last_addr = 0; last_val = 0; last_ls = 0;
      #22;
      check("rst_valid_out", {31'd0, mem_valid_out}, 32'd0);
      check("rst_addr_out", mem_addr_out, 32'd0);
      check("rst_value_out", mem_load_value_out, 32'd0);
      check("rst_inflight", {28'd0, inflight_count}, 32'd0);
      @(posedge clk); #1; reset = 1'b0;

      // Establish a known all-zero array.
      for (int a = 0; a < DEPTH; a += 4) req(a, 0, 1'b0, 1'b0);
      drain();

      req(32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0);
      req(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
      drain();

      req(32'h21, 32'h80, 1'b1, 1'b0);
      req(32'h21, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFFFFFF80);
      req(32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 32'h00008000);
      drain();

      for (int i = 0; i < 4; i++) req(4 * i, i + 1, 1'b0, 1'b0);
      drain();
      peak = 0;
      for (int i = 0; i < 4; i++) req(4 * i, 0, 1'b0, 1'b1, 1'b1, i + 1);
      drain();
      check("peak_inflight", peak, LAT);

      req(32'h403, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h0);
      req(32'h400, 32'h0, 1'b0, 1'b1, 1'b1, 32'h12345678);
      drain();

      req(32'h10, 0, 1'b0, 1'b1);
      req(32'h400, 0, 1'b0, 1'b1);
      idle(1);
      reset = 1'b1;
      exp_q.delete();
      last_addr = 0; last_val = 0; last_ls = 0;
      mem_valid = 1'b1; mem_LS = 1'b0; mem_BMS = 1'b0;
      mem_address = 32'h10; mem_store_value = 32'hBAD0BAD0;
      @(posedge clk); #1;
      mem_valid = 1'b0;
      reset = 1'b0;
      idle(2 * LAT);
      check("post_rst_inflight", {28'd0, inflight_count}, 32'd0);
      req(32'h10, 0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
      drain();

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(9) < 7) begin
            req($urandom_range(2 * DEPTH - 1), $urandom, 1'($urandom_range(1)),
                1'($urandom_range(1)));
         end else begin
            idle(1);
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
